// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared defaults and even-parity helper for the FP register file
package fp_rf_pkg;
  localparam int FP_DATA_W   = 32;
  localparam int FP_NUM_REGS = 32;
  localparam int PAR_MAX_W   = 256;
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/fp_rf_scoreboard.sv
// fp_rf_scoreboard: per-register busy tracking with RAW/WAW hazard detection
module fp_rf_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NUM_REGS = FP_NUM_REGS,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*IDX_W-1:0] i_rd_index,
  input  logic [NUM_RD-1:0]       i_rd_valid,
  input  logic [NUM_WR-1:0]       i_wr_en,
  input  logic [NUM_WR*IDX_W-1:0] i_wr_index,
  input  logic                    i_issue_en,
  input  logic [IDX_W-1:0]        i_issue_index,
  input  logic                    i_flush,
  output logic                    o_raw_hazard,
  output logic                    o_waw_hazard,
  output logic [NUM_REGS-1:0]     o_busy_vec
);
  logic [NUM_REGS-1:0] busy_q, busy_d, wr_hit;
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (i_wr_en[w]) wr_hit[i_wr_index[w*IDX_W +: IDX_W]] = 1'b1;
    busy_d = i_flush ? '0 : (busy_q & ~wr_hit);
    // issue outranks a same-cycle write so the newest producer stays tracked
    if (!i_flush && i_issue_en) busy_d[i_issue_index] = 1'b1;
    o_raw_hazard = 1'b0;
    for (int r = 0; r < NUM_RD; r++)
      o_raw_hazard = o_raw_hazard | (i_rd_valid[r] & busy_q[i_rd_index[r*IDX_W +: IDX_W]]
                                     & ~wr_hit[i_rd_index[r*IDX_W +: IDX_W]]);
    o_waw_hazard = i_issue_en & busy_q[i_issue_index] & ~wr_hit[i_issue_index];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  assign o_busy_vec = busy_q;
endmodule

// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: multi-port FP register file with bypass and scoreboard; FP_RF_PARITY_EN adds sticky parity check
module fp_regfile_sb
  import fp_rf_pkg::*;
#(
  parameter int DATA_W   = FP_DATA_W,
  parameter int NUM_REGS = FP_NUM_REGS,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*IDX_W-1:0]  i_rd_index,
  input  logic [NUM_RD-1:0]        i_rd_valid,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*IDX_W-1:0]  i_wr_index,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_issue_en,
  input  logic [IDX_W-1:0]         i_issue_index,
  input  logic                     i_flush,
  output logic                     o_raw_hazard,
  output logic                     o_waw_hazard,
  output logic [NUM_REGS-1:0]      o_busy_vec,
  output logic                     o_parity_err
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++)
      if (i_wr_en[w]) mem_d[i_wr_index[w*IDX_W +: IDX_W]] = i_wr_data[w*DATA_W +: DATA_W];
  end
  always_comb begin
    o_rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      o_rd_data[r*DATA_W +: DATA_W] = mem_q[i_rd_index[r*IDX_W +: IDX_W]];
      for (int w = 0; w < NUM_WR; w++)
        if (i_wr_en[w] && i_wr_index[w*IDX_W +: IDX_W] == i_rd_index[r*IDX_W +: IDX_W])
          o_rd_data[r*DATA_W +: DATA_W] = i_wr_data[w*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
`ifdef FP_RF_PARITY_EN
  logic par_q [NUM_REGS];
  logic par_d [NUM_REGS];
  logic err_q, err_d;
  function automatic logic [PAR_MAX_W-1:0] widen(input logic [DATA_W-1:0] d);
    widen = '0;
    widen[DATA_W-1:0] = d;
  endfunction
  always_comb begin
    logic hit;
    par_d = par_q;
    for (int w = 0; w < NUM_WR; w++)
      if (i_wr_en[w]) par_d[i_wr_index[w*IDX_W +: IDX_W]] = even_par(widen(i_wr_data[w*DATA_W +: DATA_W]));
    err_d = err_q;
    // only reads served from storage can expose a corrupted entry
    for (int r = 0; r < NUM_RD; r++) begin
      hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++)
        hit = hit | (i_wr_en[w] && i_wr_index[w*IDX_W +: IDX_W] == i_rd_index[r*IDX_W +: IDX_W]);
      if (i_rd_valid[r] && !hit && even_par(widen(mem_q[i_rd_index[r*IDX_W +: IDX_W]]))
          != par_q[i_rd_index[r*IDX_W +: IDX_W]]) err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par_q <= '{default: 1'b0};
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  assign o_parity_err = err_q;
`else
  assign o_parity_err = 1'b0;
`endif
  fp_rf_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .IDX_W(IDX_W)
  ) u_sb (
    .clk(clk), .rst(rst),
    .i_rd_index(i_rd_index), .i_rd_valid(i_rd_valid),
    .i_wr_en(i_wr_en), .i_wr_index(i_wr_index),
    .i_issue_en(i_issue_en), .i_issue_index(i_issue_index), .i_flush(i_flush),
    .o_raw_hazard(o_raw_hazard), .o_waw_hazard(o_waw_hazard), .o_busy_vec(o_busy_vec)
  );
endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
- Parametrised floating-point register file with a built-in scoreboard, successor to the single-write, two-read FP register file.
- Provides NUM_RD combinational read ports (three by default, enough for fused multiply-add), NUM_WR prioritised write ports (writeback stage plus long-latency divide/sqrt unit), same-cycle write-to-read bypass, and per-register busy tracking.
- Raises RAW/WAW hazard flags to the decode stage.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of FP registers; power of two, at least 2.
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports; a higher port index has higher priority.
- IDX_W, $clog2(NUM_REGS), register index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_rd_index  in  NUM_RD*IDX_W  read indices; port r occupies slice [r*IDX_W +: IDX_W]
- i_rd_valid  in  NUM_RD  read port r is used by the instruction in decode
- o_rd_data  out  NUM_RD*DATA_W  read data, combinational
- i_wr_en  in  NUM_WR  write enables
- i_wr_index  in  NUM_WR*IDX_W  write indices
- i_wr_data  in  NUM_WR*DATA_W  write data
- i_issue_en  in  1  an instruction with an FP destination issues this cycle
- i_issue_index  in  IDX_W  destination of the issuing instruction
- i_flush  in  1  clears all busy bits (pipeline flush)
- o_raw_hazard  out  1  some valid read targets a pending register
- o_waw_hazard  out  1  the issue destination is already pending
- o_busy_vec  out  NUM_REGS  registered busy bits
- o_parity_err  out  1  sticky parity error (FP_RF_PARITY_EN only; otherwise tied 0)

Behaviour:
- Reset (async, rst=1): all registers 0, all busy bits 0, o_parity_err 0. Outputs settle combinationally to: o_rd_data=0 unless bypassed, hazards 0.
- Write commit: on posedge, register i_wr_index[w] takes i_wr_data[w] for every enabled w.
  - If two enabled ports target the same index, the highest w wins.
  - Different indices commit in parallel.
- Read, combinational:
  - If any enabled write port matches the read index, the highest such port's data is returned (bypass).
  - Otherwise the stored value is returned.
  - Bypass applies to every index, including 0 (no hardwired zero register).
- Busy next-state per register i, on posedge, in priority order:
  - i_flush: busy=0 for all registers.
  - else if i_issue_en and i_issue_index==i: busy=1. Issue beats a same-cycle write, so the new producer is tracked.
  - else if any i_wr_en[w] with i_wr_index[w]==i: busy=0.
  - else: hold.
- o_raw_hazard = OR over r of (i_rd_valid[r] & busy[idx_r] & no enabled write to idx_r this cycle).
  - A same-cycle write resolves the hazard through the bypass.
- o_waw_hazard = i_issue_en & busy[i_issue_index] & no enabled write to that index this cycle.
  - The block still performs the issue; decode must stall instead of asserting i_issue_en.
- Latency:
  - Write visible on the read port in the same cycle via bypass; from storage the next cycle.
  - Busy set is visible on o_busy_vec one cycle after issue.
- Reset mid-operation clears storage and busy bits immediately. In-flight writes are lost.

Optional Feature:
- Macro FP_RF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on the committed data.
  - On each posedge, any valid read port whose data comes from storage (not bypass) with mismatched parity sets o_parity_err=1.
  - o_parity_err is sticky until rst.
- Undefined: no parity storage; o_parity_err is constant 0.

Decomposition:
- Package fp_rf_pkg holds: the default DATA_W/NUM_REGS constants and a function computing even parity.
- One sub-module, fp_rf_scoreboard, holds the busy vector, flush/issue/write clear logic and both hazard outputs.
- The top level holds storage, write priority, bypass muxes and parity.

Test Plan:
- Reset, then read indices 0, 5, 31 with no writes -> all o_rd_data=0, o_busy_vec=0, no hazards.
- Write port0 idx3=0x3F800000 and port1 idx3=0x40000000 in the same cycle; read idx3 that cycle and the next -> 0x40000000 both times.
- Issue idx7 at cycle T, then read port0 valid idx7 at T+1 -> o_raw_hazard=1. Write idx7=0x41200000 at T+3 -> hazard 0 that cycle, data bypassed, busy[7]=0 at T+4.
- Issue idx9 while busy[9]=1 -> o_waw_hazard=1. Issue idx9 in the same cycle as a write to idx9 -> no WAW, and busy[9] remains 1 afterwards.
- Set busy on idx1, 2 and 30, then assert i_flush with a simultaneous issue to idx4 -> o_busy_vec=0 next cycle.
- With FP_RF_PARITY_EN, force a stored bit flip on idx12, then read idx12 valid -> o_parity_err=1 next cycle and held until rst.
